// File: rtl/mux_scan_n.sv
// Registered N:1 channel multiplexer with manual select or masked round-robin scan.
// The selected word is held in an output register and released with a valid/ready handshake.
module mux_scan_n #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [CHANNELS-1:0]       mask,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          dout_ch,
    output logic                      out_valid,
    output logic                      sel_err
);

    localparam logic [SEL_W:0]   CH_LIM  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] dout_q,      dout_d;
    logic [SEL_W-1:0] dout_ch_q,   dout_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q,   sel_err_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    logic             scan_found;
    logic [SEL_W-1:0] scan_idx;
    logic [SEL_W:0]   cand;
    logic             manual_ok;
    logic             stage_free;
    logic             target_ok;
    logic [SEL_W-1:0] target;
    logic             capture;

    // Search upward from ptr+1 with wrap; ptr itself is the last candidate.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = {1'b0, ptr_q} + (SEL_W+1)'(i);
            if (cand >= CH_LIM) begin
                cand = cand - CH_LIM;
            end
            if (!scan_found && mask[cand[SEL_W-1:0]]) begin
                scan_found = 1'b1;
                scan_idx   = cand[SEL_W-1:0];
            end
        end
    end

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        manual_ok   = ({1'b0, sel_in} < CH_LIM);
        stage_free  = !out_valid_q || out_ready;
        target      = mode ? scan_idx : sel_in;
        target_ok   = mode ? scan_found : manual_ok;
        capture     = en && stage_free && target_ok;

        dout_d      = dout_q;
        dout_ch_d   = dout_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        sel_err_d   = en && stage_free && !mode && !manual_ok;

        if (capture) begin
            dout_d      = din[target*WIDTH +: WIDTH];
            dout_ch_d   = target;
            out_valid_d = 1'b1;
            ptr_d       = target;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q      <= '0;
            dout_ch_q   <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            ptr_q       <= PTR_RST;
        end else begin
            dout_q      <= dout_d;
            dout_ch_q   <= dout_ch_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            ptr_q       <= ptr_d;
        end
    end

    assign dout      = dout_q;
    assign dout_ch   = dout_ch_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

endmodule
